uart_core: RTL and testbench

//  Full-duplex 8N1 UART: parallel-load serial transmitter plus 16x-oversampling receiver.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx.sv | 131 +++++++++++++
 rtl/uart_core.sv | 69 ++++++
 tb/tb_uart_core.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the 8N1 UART: frame geometry, oversampling
// rate and the receiver state encoding.
package uart_pkg;

   localparam int DATA_W     = 8;
   localparam int OSR        = 16;
   localparam int MID_SAMPLE = 7;
   localparam int CNT_W      = $clog2(OSR);
   localparam int TX_CNT_W   = 4;

   // Transmit counter value at which the stop bit has been fully driven.
   localparam logic [TX_CNT_W-1:0] TX_LAST = TX_CNT_W'(DATA_W + 2);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 receiver: two-flop input synchroniser, frame FSM and
// receive holding register with an empty flag.
module uart_rx
   import uart_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              rxclk,
   input  logic              uld_rx_data,
   input  logic              rx_enable,
   input  logic              rx_in,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_empty,
   output rx_state_t         rx_state
);

   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(MID_SAMPLE);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OSR - 1);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_W - 1);

   logic              rx_sync1, rx_sync2;
   rx_state_t         state, state_nxt;
   logic [CNT_W-1:0]  sample_cnt, cnt_nxt;
   logic [2:0]        bit_cnt, bit_nxt;
   logic [DATA_W-1:0] shift_reg, shift_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              empty_nxt;
   logic              wait_high, wait_nxt;

   // Synchroniser resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_sync1 <= 1'b1;
         rx_sync2 <= 1'b1;
      end else begin
         rx_sync1 <= rx_in;
         rx_sync2 <= rx_sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RX_IDLE;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         wait_high  <= 1'b0;
         rx_data    <= '0;
         rx_empty   <= 1'b1;
      end else begin
         state      <= state_nxt;
         sample_cnt <= cnt_nxt;
         bit_cnt    <= bit_nxt;
         shift_reg  <= shift_nxt;
         wait_high  <= wait_nxt;
         rx_data    <= data_nxt;
         rx_empty   <= empty_nxt;
      end
   end

   // Unload is applied first so a byte completing in the same cycle overrides it.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = sample_cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift_reg;
      wait_nxt  = wait_high;
      data_nxt  = rx_data;
      empty_nxt = rx_empty;

      if (uld_rx_data)
         empty_nxt = 1'b1;

      if (!rx_enable) begin
         state_nxt = RX_IDLE;
         cnt_nxt   = '0;
         bit_nxt   = '0;
      end else if (rxclk) begin
         case (state)
            RX_IDLE: begin
               if (wait_high) begin
                  if (rx_sync2)
                     wait_nxt = 1'b0;
               end else if (!rx_sync2) begin
                  state_nxt = RX_START;
                  cnt_nxt   = '0;
               end
            end
            RX_START: begin
               if (sample_cnt == MID_CNT) begin
                  cnt_nxt = '0;
                  bit_nxt = '0;
                  state_nxt = rx_sync2 ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_nxt = sample_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (sample_cnt == LAST_CNT) begin
                  cnt_nxt   = '0;
                  shift_nxt = {rx_sync2, shift_reg[DATA_W-1:1]};
                  bit_nxt   = bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT)
                     state_nxt = RX_STOP;
               end else begin
                  cnt_nxt = sample_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (sample_cnt == LAST_CNT) begin
                  cnt_nxt   = '0;
                  state_nxt = RX_IDLE;
                  if (rx_sync2) begin
                     data_nxt  = shift_reg;
                     empty_nxt = 1'b0;
                  end else begin
                     // Framing error: drop the byte and ignore the low line until it recovers.
                     wait_nxt = 1'b1;
                  end
               end else begin
                  cnt_nxt = sample_cnt + 1'b1;
               end
            end
            default: state_nxt = RX_IDLE;
         endcase
      end
   end

   assign rx_state = state;

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: parallel-load transmitter driven by a 1x baud strobe
// plus the oversampling receiver, all in one clock domain.
module uart_core
   import uart_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              txclk,
   input  logic              ld_tx_data,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_enable,
   input  logic              rxclk,
   input  logic              uld_rx_data,
   input  logic              rx_enable,
   input  logic              rx_in,
   output logic              tx_out,
   output logic              tx_empty,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_empty,
   output rx_state_t         rx_state
);

   // Handshakes: ld_tx_data is accepted only while tx_empty=1 (otherwise dropped);
   // rx_empty=0 flags a byte in rx_data, and uld_rx_data acknowledges it.
   logic [DATA_W-1:0]   tx_reg;
   logic [TX_CNT_W-1:0] tx_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_reg   <= '0;
         tx_cnt   <= '0;
         tx_empty <= 1'b1;
         tx_out   <= 1'b1;
      end else begin
         if (ld_tx_data && tx_empty) begin
            tx_reg   <= tx_data;
            tx_empty <= 1'b0;
         end
         // tx_cnt counts strobes already taken: 0 -> start bit, 1..8 -> data, 9 -> stop.
         if (txclk && tx_enable && !tx_empty) begin
            if (tx_cnt == TX_LAST) begin
               tx_cnt   <= '0;
               tx_empty <= 1'b1;
            end else begin
               tx_cnt <= tx_cnt + 1'b1;
               if (tx_cnt == '0)
                  tx_out <= 1'b0;
               else if (tx_cnt <= TX_CNT_W'(DATA_W))
                  tx_out <= tx_reg[3'(tx_cnt - 1'b1)];
               else
                  tx_out <= 1'b1;
            end
         end
      end
   end

   uart_rx u_rx (
      .clk         (clk),
      .reset       (reset),
      .rxclk       (rxclk),
      .uld_rx_data (uld_rx_data),
      .rx_enable   (rx_enable),
      .rx_in       (rx_in),
      .rx_data     (rx_data),
      .rx_empty    (rx_empty),
      .rx_state    (rx_state)
   );

endmodule

// File: tb/tb_uart_core.sv
// Randomised bench for uart_core: an independent serial decoder and a
// receive-side monitor check every frame against expected-byte queues.
module tb_uart_core;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       txclk, rxclk;
   logic       ld_tx_data = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_enable = 1'b1;
   logic       uld_rx_data = 1'b0;
   logic       rx_enable = 1'b1;
   logic       rx_in;
   logic       tx_out, tx_empty, rx_empty;
   logic [7:0] rx_data;
   rx_state_t  rx_state;

   logic       loop_sel = 1'b1;
   logic       bench_rx = 1'b1;
   logic       mon_en = 1'b1;
   logic [4:0] div = '0;
   logic [7:0] last_rx = '0;

   int total = 0;
   int bad = 0;
   logic [7:0] exp_tx_q[$];
   logic [7:0] exp_rx_q[$];

   always #5 clk = ~clk;

   // One bit period is 32 clocks: txclk once per period, rxclk 16 times.
   initial forever begin
      @(negedge clk);
      div = div + 5'd1;
   end
   assign txclk = (div == 5'd0);
   assign rxclk = ~div[0];
   assign rx_in = loop_sel ? tx_out : bench_rx;

   uart_core dut (
      .clk         (clk),
      .reset       (reset),
      .txclk       (txclk),
      .ld_tx_data  (ld_tx_data),
      .tx_data     (tx_data),
      .tx_enable   (tx_enable),
      .rxclk       (rxclk),
      .uld_rx_data (uld_rx_data),
      .rx_enable   (rx_enable),
      .rx_in       (rx_in),
      .tx_out      (tx_out),
      .tx_empty    (tx_empty),
      .rx_data     (rx_data),
      .rx_empty    (rx_empty),
      .rx_state    (rx_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_for(input bit on_rx, input logic val, input int limit, input string name);
      int n;
      n = 0;
      while (((on_rx ? rx_empty : tx_empty) !== val) && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      if ((on_rx ? rx_empty : tx_empty) !== val)
         check(name, 32'(on_rx ? rx_empty : tx_empty), 32'(val));
   endtask

   task automatic wait_rxclk(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (rxclk !== 1'b1);
         #1;
      end
   endtask

   task automatic send_tx(input logic [7:0] b);
      wait_for(1'b0, 1'b1, 1000, "tx_ready_timeout");
      tx_data = b;
      ld_tx_data = 1'b1;
      @(posedge clk); #1;
      ld_tx_data = 1'b0;
      check("tx_load", 32'(tx_empty), 32'd0);
      if (mon_en) begin
         exp_tx_q.push_back(b);
         if (loop_sel) exp_rx_q.push_back(b);
      end
   endtask

   task automatic unload();
      uld_rx_data = 1'b1;
      @(posedge clk); #1;
      uld_rx_data = 1'b0;
      check("uld_empty", 32'(rx_empty), 32'd1);
   endtask

   task automatic loop_byte(input logic [7:0] b);
      send_tx(b);
      wait_for(1'b1, 1'b0, 1000, "rx_timeout");
      check("loop_data", 32'(rx_data), 32'(b));
      last_rx = b;
      wait_for(1'b0, 1'b1, 1000, "tx_done_timeout");
      unload();
   endtask

   task automatic rx_bit(input logic v);
      bench_rx = v;
      wait_rxclk(OSR);
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop);
      rx_bit(1'b0);
      for (int i = 0; i < 8; i++) rx_bit(b[i]);
      rx_bit(stop);
      bench_rx = 1'b1;
   endtask

   // Independent decoder: finds the start edge and samples each bit at its centre.
   initial begin : tx_mon
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (mon_en && !reset && prev && !tx_out) begin
            repeat (16) @(posedge clk);
            #1;
            check("tx_start_bit", 32'(tx_out), 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (32) @(posedge clk);
               #1;
               b[i] = tx_out;
            end
            repeat (32) @(posedge clk);
            #1;
            check("tx_stop_bit", 32'(tx_out), 32'd1);
            if (exp_tx_q.size() == 0) check("tx_unexpected", 32'(b), 32'hFFFF);
            else check("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
         end
         prev = tx_out;
      end
   end

   initial begin : rx_mon
      logic prev_e;
      prev_e = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (reset) prev_e = 1'b1;
         else begin
            if (prev_e && !rx_empty) begin
               if (exp_rx_q.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF);
               else check("rx_byte", 32'(rx_data), 32'(exp_rx_q.pop_front()));
            end
            prev_e = rx_empty;
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [7:0] b;
      #1 reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_tx_out", 32'(tx_out), 32'd1);
      check("rst_tx_empty", 32'(tx_empty), 32'd1);
      check("rst_rx_empty", 32'(rx_empty), 32'd1);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_rx_state", 32'(rx_state), 32'(RX_IDLE));
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Directed 0xA5: per-tick line level, then empty on tick 11.
      b = 8'hA5;
      send_tx(b);
      for (int k = 1; k <= 11; k++) begin
         do @(posedge clk); while (txclk !== 1'b1);
         #1;
         if (k == 1) check("a5_tick1", 32'(tx_out), 32'd0);
         else if (k <= 9) check($sformatf("a5_tick%0d", k), 32'(tx_out), 32'(b[k-2]));
         else if (k == 10) begin
            check("a5_tick10", 32'(tx_out), 32'd1);
            check("a5_busy_tick10", 32'(tx_empty), 32'd0);
         end else check("a5_empty_tick11", 32'(tx_empty), 32'd1);
      end
      wait_for(1'b1, 1'b0, 100, "a5_rx_timeout");
      unload();

      loop_byte(8'h3C);
      for (int i = 0; i < 8; i++) loop_byte(8'($urandom_range(0, 255)));

      // Receiver-only tests drive the line from the bench.
      loop_sel = 1'b0;
      bench_rx = 1'b0;
      wait_rxclk(4);
      bench_rx = 1'b1;
      wait_rxclk(40);
      check("glitch_empty", 32'(rx_empty), 32'd1);
      check("glitch_idle", 32'(rx_state), 32'(RX_IDLE));

      b = 8'($urandom_range(0, 255));
      exp_rx_q.push_back(b);
      rx_frame(b, 1'b1);
      wait_for(1'b1, 1'b0, 200, "post_glitch_timeout");
      last_rx = b;
      unload();

      rx_frame(8'h55, 1'b0);
      wait_rxclk(40);
      check("framing_empty", 32'(rx_empty), 32'd1);
      check("framing_data", 32'(rx_data), 32'(last_rx));

      b = 8'($urandom_range(0, 255));
      exp_rx_q.push_back(b);
      rx_frame(b, 1'b1);
      wait_for(1'b1, 1'b0, 200, "post_framing_timeout");
      check("post_framing_data", 32'(rx_data), 32'(b));
      last_rx = b;
      unload();

      // Disabling mid-frame drops it; the rest of an all-ones frame is just idle line.
      rx_bit(1'b0);
      rx_bit(1'b1);
      rx_enable = 1'b0;
      rx_bit(1'b1);
      rx_enable = 1'b1;
      for (int i = 0; i < 7; i++) rx_bit(1'b1);
      wait_rxclk(32);
      check("disable_empty", 32'(rx_empty), 32'd1);
      check("disable_idle", 32'(rx_state), 32'(RX_IDLE));

      // Second load while busy is ignored.
      loop_sel = 1'b1;
      wait_for(1'b0, 1'b1, 1000, "ovr_ready_timeout");
      tx_data = 8'h11;
      ld_tx_data = 1'b1;
      @(posedge clk); #1;
      tx_data = 8'h22;
      @(posedge clk); #1;
      ld_tx_data = 1'b0;
      exp_tx_q.push_back(8'h11);
      exp_rx_q.push_back(8'h11);
      wait_for(1'b1, 1'b0, 1000, "ovr_rx_timeout");
      check("ovr_tx_first", 32'(rx_data), 32'h11);
      wait_for(1'b0, 1'b1, 1000, "ovr_tx_timeout");
      repeat (80) @(posedge clk);
      #1;
      check("ovr_tx_idle_empty", 32'(tx_empty), 32'd1);
      check("ovr_tx_idle_line", 32'(tx_out), 32'd1);
      unload();

      // Two unread bytes: the later one overwrites.
      loop_sel = 1'b0;
      exp_rx_q.push_back(8'h5A);
      rx_frame(8'h5A, 1'b1);
      rx_frame(8'hC3, 1'b1);
      wait_rxclk(8);
      check("overrun_data", 32'(rx_data), 32'hC3);
      check("overrun_full", 32'(rx_empty), 32'd0);

      // Reset in the middle of a loopback frame with an unread byte pending.
      mon_en = 1'b0;
      loop_sel = 1'b1;
      send_tx(8'h96);
      repeat (150) @(posedge clk);
      #1;
      check("mid_busy", 32'(tx_empty), 32'd0);
      reset = 1'b1;
      #1;
      check("mid_rst_tx_out", 32'(tx_out), 32'd1);
      check("mid_rst_tx_empty", 32'(tx_empty), 32'd1);
      check("mid_rst_rx_empty", 32'(rx_empty), 32'd1);
      check("mid_rst_rx_data", 32'(rx_data), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (400) @(posedge clk);
      #1;
      check("post_rst_rx_empty", 32'(rx_empty), 32'd1);
      check("post_rst_tx_out", 32'(tx_out), 32'd1);
      check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
      check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
